// File: rtl/pwm_pkg.sv
// Shared widths, dead-time state encoding and duty clamp helper for the PWM stage.
package pwm_pkg;

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned DT_W   = 4;
  localparam int unsigned U_W    = 17;
  localparam int unsigned DUTY_W = CNT_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OFF  = 3'd1,
    DT_H = 3'd2,
    ON   = 3'd3,
    DT_L = 3'd4
  } dt_state_e;

  typedef struct packed {
    logic              sat;
    logic [DUTY_W-1:0] duty;
  } clamp_t;

  // Clamp a signed control word into [0, per+1]; flag when clamping happened.
  function automatic clamp_t clamp_duty(input logic signed [U_W-1:0] src,
                                        input logic [CNT_W-1:0]      per);
    clamp_t            res;
    logic [DUTY_W-1:0] lim;
    lim = {1'b0, per} + DUTY_W'(1);
    if (src[U_W-1]) begin
      res.duty = '0;
      res.sat  = 1'b1;
    end else if (src[U_W-2:0] > (U_W-1)'(lim)) begin
      res.duty = lim;
      res.sat  = 1'b1;
    end else begin
      res.duty = src[CNT_W:0];
      res.sat  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate generator with dead-time insertion on every rising edge
// of either gate. Outputs are registered together with the state.
module pwm_deadtime
  import pwm_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] dt_act,
  output logic            h,
  output logic            l
);

  dt_state_e       state;
  logic [DT_W-1:0] dt_cnt;

  // Dead-time FSM: IDLE while disabled, otherwise OFF/DT_H/ON/DT_L around raw.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      dt_cnt <= '0;
      h      <= 1'b0;
      l      <= 1'b0;
    end else if (!en) begin
      state  <= IDLE;
      dt_cnt <= '0;
      h      <= 1'b0;
      l      <= 1'b0;
    end else begin
      case (state)
        IDLE, OFF: begin
          if (!raw) begin
            state <= OFF;
            h     <= 1'b0;
            l     <= 1'b1;
          end else if (dt_act == '0) begin
            state <= ON;
            h     <= 1'b1;
            l     <= 1'b0;
          end else begin
            state  <= DT_H;
            dt_cnt <= dt_act;
            h      <= 1'b0;
            l      <= 1'b0;
          end
        end
        DT_H: begin
          if (!raw) begin
            state <= OFF;
            h     <= 1'b0;
            l     <= 1'b1;
          end else if (dt_cnt <= DT_W'(1)) begin
            state <= ON;
            h     <= 1'b1;
            l     <= 1'b0;
          end else begin
            dt_cnt <= dt_cnt - DT_W'(1);
            h      <= 1'b0;
            l      <= 1'b0;
          end
        end
        ON: begin
          if (raw) begin
            h <= 1'b1;
            l <= 1'b0;
          end else if (dt_act == '0) begin
            state <= OFF;
            h     <= 1'b0;
            l     <= 1'b1;
          end else begin
            state  <= DT_L;
            dt_cnt <= dt_act;
            h      <= 1'b0;
            l      <= 1'b0;
          end
        end
        DT_L: begin
          if (raw) begin
            if (dt_act == '0) begin
              state <= ON;
              h     <= 1'b1;
              l     <= 1'b0;
            end else begin
              state  <= DT_H;
              dt_cnt <= dt_act;
              h      <= 1'b0;
              l      <= 1'b0;
            end
          end else if (dt_cnt <= DT_W'(1)) begin
            state <= OFF;
            h     <= 1'b0;
            l     <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - DT_W'(1);
            h      <= 1'b0;
            l      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          h     <= 1'b0;
          l     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_drive.sv
// Edge-aligned PWM stage: period counter, double-buffered duty/period/dead
// shadows loaded on wrap, duty clamp, and complementary gate drive.
module pwm_drive
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [U_W-1:0]   u_in,
  input  logic             u_valid,
  input  logic [CNT_W-1:0] period,
  input  logic [DT_W-1:0]  dead,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             period_start,
  output logic             sat
);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  per_act;
  logic [DUTY_W-1:0] duty_act;
  logic [DT_W-1:0]   dt_act;
  logic [U_W-1:0]    pend;

  logic              wrap_c;
  logic              raw_c;
  logic [U_W-1:0]    src_c;
  clamp_t            clamp_c;

  // A sample arriving on the wrap cycle bypasses the pending register.
  assign wrap_c  = en && (cnt == per_act);
  assign src_c   = u_valid ? u_in : pend;
  assign clamp_c = clamp_duty(src_c, period);
  assign raw_c   = en && ({1'b0, cnt} < duty_act);

  // Counter, pending capture and shadow load on the period boundary.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt          <= '0;
      per_act      <= '0;
      duty_act     <= '0;
      dt_act       <= '0;
      pend         <= '0;
      period_start <= 1'b0;
      sat          <= 1'b0;
    end else begin
      if (u_valid) pend <= u_in;
      period_start <= wrap_c;
      if (!en) begin
        cnt <= '0;
      end else if (wrap_c) begin
        cnt      <= '0;
        per_act  <= period;
        dt_act   <= dead;
        duty_act <= clamp_c.duty;
        sat      <= clamp_c.sat;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  pwm_deadtime u_deadtime (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .raw    (raw_c),
    .dt_act (dt_act),
    .h      (pwm_h),
    .l      (pwm_l)
  );

endmodule

// File: tb/tb_pwm_drive.sv
// Bench for pwm_drive: reset/enable vector table, directed multi-cycle
// sequences and a randomized run against a run-length reference model.
module tb_pwm_drive;
  import pwm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn;
  logic             en;
  logic             u_valid;
  logic [U_W-1:0]   u_in;
  logic [CNT_W-1:0] period;
  logic [DT_W-1:0]  dead;
  logic             pwm_h;
  logic             pwm_l;
  logic             period_start;
  logic             sat;

  pwm_drive dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .u_in         (u_in),
    .u_valid      (u_valid),
    .period       (period),
    .dead         (dead),
    .pwm_h        (pwm_h),
    .pwm_l        (pwm_l),
    .period_start (period_start),
    .sat          (sat)
  );

  int checks = 0;
  int errors = 0;

  // stimulus values applied on the next step
  logic d_rstn = 1'b0;
  logic d_en   = 1'b0;
  logic d_uv   = 1'b0;
  int   d_u    = 0;
  int   d_per  = 0;
  int   d_dead = 0;

  // reference model state
  int   m_cnt, m_per, m_duty, m_dt, m_pend;
  int   hi_run, lo_run, run_dt_hi, run_dt_lo;
  logic m_ps, m_sat, m_h, m_l, was_on;

  typedef struct {
    logic rstn;
    logic en;
    logic uv;
    int   u;
    logic h;
    logic l;
    logic ps;
    logic sat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_per = 0; m_duty = 0; m_dt = 0; m_pend = 0;
    hi_run = 0; lo_run = 0; run_dt_hi = 0; run_dt_lo = 0;
    m_ps = 1'b0; m_sat = 1'b0; m_h = 1'b0; m_l = 1'b0; was_on = 1'b0;
  endtask

  // Gate model: high side needs raw high for dead+1 consecutive clocks; low
  // side needs raw low for dead+1 clocks after a completed high pulse, or
  // returns at once when the high side never turned on.
  task automatic model_step();
    logic raw;
    int   src;
    if (!d_rstn) begin
      model_reset();
      return;
    end
    raw = d_en && (m_cnt < m_duty);
    if (!d_en) begin
      m_h = 1'b0; m_l = 1'b0; hi_run = 0; lo_run = 0; was_on = 1'b0;
    end else if (raw) begin
      if (hi_run == 0) begin
        run_dt_hi = m_dt;
        was_on = 1'b0;
      end
      hi_run++;
      lo_run = 0;
      m_h = (hi_run > run_dt_hi);
      if (m_h) was_on = 1'b1;
      m_l = 1'b0;
    end else begin
      if (lo_run == 0) run_dt_lo = m_dt;
      lo_run++;
      hi_run = 0;
      m_h = 1'b0;
      m_l = !was_on || (lo_run > run_dt_lo);
    end
    m_ps = 1'b0;
    if (d_en) begin
      if (m_cnt == m_per) begin
        src = d_uv ? d_u : m_pend;
        if (src < 0) begin
          m_duty = 0; m_sat = 1'b1;
        end else if (src > d_per + 1) begin
          m_duty = d_per + 1; m_sat = 1'b1;
        end else begin
          m_duty = src; m_sat = 1'b0;
        end
        m_per = d_per;
        m_dt  = d_dead;
        m_cnt = 0;
        m_ps  = 1'b1;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
    end
    if (d_uv) m_pend = d_u;
  endtask

  // One clock: drive at negedge, check 1 time unit after the posedge.
  task automatic step();
    rstn    = d_rstn;
    en      = d_en;
    u_valid = d_uv;
    u_in    = U_W'(d_u);
    period  = CNT_W'(d_per);
    dead    = DT_W'(d_dead);
    model_step();
    @(posedge clk);
    #1;
    check("pwm_h", int'(pwm_h), int'(m_h));
    check("pwm_l", int'(pwm_l), int'(m_l));
    check("period_start", int'(period_start), int'(m_ps));
    check("sat", int'(sat), int'(m_sat));
    check("overlap", int'(pwm_h & pwm_l), 0);
    @(negedge clk);
    d_uv = 1'b0;
  endtask

  task automatic load(input int u);
    d_uv = 1'b1;
    d_u  = u;
    step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sync_ps();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (period_start) seen = 1'b1;
    end
    check("sync_timeout", int'(seen), 1);
  endtask

  task automatic wait_h();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (pwm_h) seen = 1'b1;
    end
    check("wait_h_timeout", int'(seen), 1);
  endtask

  // Count gate activity over n clocks; optionally present a sample at uv_idx.
  task automatic window(input int n, input int uv_idx, input int uv_val,
                        output int hc, output int lc, output int bl);
    hc = 0; lc = 0; bl = 0;
    for (int i = 0; i < n; i++) begin
      if (i == uv_idx) begin
        d_uv = 1'b1;
        d_u  = uv_val;
      end
      step();
      if (pwm_h) hc++;
      if (pwm_l) lc++;
      if (!pwm_h && !pwm_l) bl++;
    end
  endtask

  initial begin
    int hc, lc, bl, n;
    int pers[7];
    logic seen;

    pers = '{0, 1, 2, 3, 5, 9, 15};
    rstn = 1'b0; en = 1'b0; u_valid = 1'b0; u_in = '0; period = '0; dead = '0;
    model_reset();

    vecs[0]  = '{1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0};

    @(negedge clk);

    // reset, then first enabled cycle wraps and loads period 9 / duty 4
    d_per = 9; d_dead = 0;
    for (int i = 0; i < 15; i++) begin
      d_rstn = vecs[i].rstn;
      d_en   = vecs[i].en;
      d_uv   = vecs[i].uv;
      d_u    = vecs[i].u;
      step();
      check($sformatf("vec%0d_h", i), int'(pwm_h), int'(vecs[i].h));
      check($sformatf("vec%0d_l", i), int'(pwm_l), int'(vecs[i].l));
      check($sformatf("vec%0d_ps", i), int'(period_start), int'(vecs[i].ps));
      check($sformatf("vec%0d_sat", i), int'(sat), int'(vecs[i].sat));
    end

    // dead time 3 on a 20-clock period with duty 10
    d_per = 19; d_dead = 3;
    load(10);
    run(60);
    sync_ps();
    window(20, -1, 0, hc, lc, bl);
    check("dt_high", hc, 7);
    check("dt_low", lc, 7);
    check("dt_gaps", bl, 6);

    // saturation: negative, above P+1, and exactly P
    d_dead = 0;
    load(-5);
    run(50);
    sync_ps();
    window(20, -1, 0, hc, lc, bl);
    check("sat_neg_high", hc, 0);
    check("sat_neg_flag", int'(sat), 1);
    load(50);
    run(50);
    sync_ps();
    window(20, -1, 0, hc, lc, bl);
    check("sat_pos_high", hc, 20);
    check("sat_pos_flag", int'(sat), 1);
    load(19);
    run(50);
    sync_ps();
    window(20, -1, 0, hc, lc, bl);
    check("nosat_high", hc, 19);
    check("nosat_flag", int'(sat), 0);

    // shadowing: mid-period update waits; wrap-cycle sample is taken directly
    d_per = 9;
    load(4);
    run(40);
    sync_ps();
    window(10, 3, 8, hc, lc, bl);
    check("shadow_cur", hc, 4);
    check("shadow_wrap_ps", int'(period_start), 1);
    window(10, 9, 2, hc, lc, bl);
    check("shadow_next", hc, 8);
    window(10, -1, 0, hc, lc, bl);
    check("shadow_wrapload", hc, 2);

    // short pulse under long dead time never turns the high side on
    d_per = 19; d_dead = 5;
    load(2);
    run(60);
    sync_ps();
    window(20, -1, 0, hc, lc, bl);
    check("short_high", hc, 0);
    check("short_l_drop", int'(lc < 20), 1);

    // reset while the high side is on
    d_dead = 0; d_per = 9;
    load(8);
    run(30);
    wait_h();
    d_rstn = 1'b0;
    step();
    check("midrst_h", int'(pwm_h), 0);
    check("midrst_l", int'(pwm_l), 0);
    check("midrst_sat", int'(sat), 0);
    d_rstn = 1'b1;
    step();
    check("rst_release_wrap", int'(period_start), 1);

    // disable while high, then resume from count 0 under old shadows
    load(8);
    run(30);
    wait_h();
    d_en = 1'b0;
    step();
    check("dis_h", int'(pwm_h), 0);
    check("dis_l", int'(pwm_l), 0);
    step();
    d_en = 1'b1;
    step();
    check("reen_h", int'(pwm_h), 1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      n++;
      if (period_start) seen = 1'b1;
    end
    check("reen_wrap_dist", n, 9);

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      d_rstn = ($urandom_range(0, 499) != 0);
      if (d_en) begin
        if ($urandom_range(0, 199) == 0) d_en = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        d_en = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        d_uv = 1'b1;
        if ($urandom_range(0, 15) == 0) d_u = int'($urandom_range(0, 131071)) - 65536;
        else d_u = int'($urandom_range(0, 100)) - 40;
      end
      if ($urandom_range(0, 63) == 0) d_per = pers[$urandom_range(0, 6)];
      if ($urandom_range(0, 63) == 0) d_dead = int'($urandom_range(0, 6));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
